// File: rtl/vldp_stream_ctrl_if.sv
// Command, memory-read and decoder-stream signals of the VLDP playback sequencer.
// master is the sequencer side; slave is the game logic / memory / decoder side.
interface vldp_stream_ctrl_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 64
);
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_ready;
  logic [ADDR_W-1:0] end_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] stream_data;
  logic              stream_valid;
  logic              stream_busy;
  logic              dec_flush;
  logic              playing;
  logic              at_end;
  logic [31:0]       stream_dat_count;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, end_addr, mem_gnt, mem_rvalid, mem_rdata, stream_busy,
    output cmd_ready, mem_req, mem_addr, stream_data, stream_valid, dec_flush, playing, at_end,
           stream_dat_count
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, end_addr, mem_gnt, mem_rvalid, mem_rdata, stream_busy,
    input  cmd_ready, mem_req, mem_addr, stream_data, stream_valid, dec_flush, playing, at_end,
           stream_dat_count
  );
endinterface

// File: rtl/vldp_stream_ctrl.sv
// VLDP playback sequencer: PLAY/PAUSE/SEEK commands drive burst reads from memory
// into a first-word-fall-through FIFO that feeds the decoder stream input.
//
// state | meaning
// IDLE  | waiting for play mode, FIFO space and a fetch address short of end_addr
// REQ   | burst request held on mem_req/mem_addr until mem_gnt
// DATA  | collecting BURST beats into the FIFO
// DRAIN | seek pending: remaining beats of the burst are swallowed
// FLUSH | dec_flush held for FLUSH_CYC cycles after a seek
module vldp_stream_ctrl #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 64,
  parameter int BURST     = 8,
  parameter int FLUSH_CYC = 4
) (
  input logic                sys_clk_i,
  input logic                rst_n_i,
  vldp_stream_ctrl_if.master bus
);
  localparam int DEPTH = 2 * BURST;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int BW    = $clog2(BURST);
  localparam int FW    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [2:0] {IDLE, REQ, DATA, DRAIN, FLUSH} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] rd_addr_q, seek_addr_q, mem_addr_q;
  logic              playing_q, at_end_q, mem_req_q, dec_flush_q;
  logic [BW-1:0]     beat_cnt_q;
  logic [FW-1:0]     flush_cnt_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [31:0]       dat_count_q;
  logic [DATA_W-1:0] fifo_q [DEPTH];

  logic              cmd_acc, is_play, is_pause, is_seek;
  logic              playing_d, can_req, last_beat, fifo_wr, fifo_pop, enter_flush, stream_valid;
  logic [ADDR_W-1:0] seek_aligned, flush_addr, next_addr;

  assign stream_valid = (count_q != '0) && (state_q != FLUSH);

  always_comb begin
    cmd_acc      = bus.cmd_valid && bus.cmd_ready;
    is_play      = cmd_acc && (bus.cmd_op == 2'b01);
    is_pause     = cmd_acc && (bus.cmd_op == 2'b10);
    is_seek      = cmd_acc && (bus.cmd_op == 2'b11);
    seek_aligned = bus.cmd_addr & ~ADDR_W'(BURST - 1);
    playing_d    = playing_q;
    if (is_play && !at_end_q) playing_d = 1'b1;
    if (is_pause)             playing_d = 1'b0;
    // decide on the post-command play flag so PLAY requests on the very next cycle
    can_req     = playing_d && !at_end_q && (count_q <= CW'(DEPTH - BURST));
    last_beat   = bus.mem_rvalid && (beat_cnt_q == BW'(BURST - 1));
    fifo_wr     = (state_q == DATA) && bus.mem_rvalid && !is_seek;
    fifo_pop    = stream_valid && !bus.stream_busy;
    next_addr   = rd_addr_q + ADDR_W'(BURST);
    enter_flush = 1'b0;
    flush_addr  = seek_aligned;
    case (state_q)
      IDLE:    enter_flush = is_seek;
      REQ:     enter_flush = is_seek && !bus.mem_gnt;
      DATA:    enter_flush = is_seek && last_beat;
      DRAIN: begin
        enter_flush = last_beat;
        flush_addr  = seek_addr_q;
      end
      default: enter_flush = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      seek_addr_q <= '0;
      mem_addr_q  <= '0;
      playing_q   <= 1'b0;
      at_end_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      dec_flush_q <= 1'b0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dat_count_q <= '0;
    end else begin
      playing_q <= playing_d;
      count_q   <= count_q + CW'(fifo_wr) - CW'(fifo_pop);
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        if (dat_count_q != '1) dat_count_q <= dat_count_q + 32'd1;
      end
      case (state_q)
        IDLE: if (!is_seek && can_req) begin
          state_q    <= REQ;
          mem_req_q  <= 1'b1;
          mem_addr_q <= rd_addr_q;
        end
        REQ: if (bus.mem_gnt) begin
          state_q     <= is_seek ? DRAIN : DATA;
          mem_req_q   <= 1'b0;
          beat_cnt_q  <= '0;
          seek_addr_q <= seek_aligned;
        end
        DATA: begin
          if (bus.mem_rvalid) beat_cnt_q <= beat_cnt_q + 1'b1;
          if (is_seek) begin
            state_q     <= DRAIN;
            seek_addr_q <= seek_aligned;
          end else if (last_beat) begin
            state_q   <= IDLE;
            rd_addr_q <= next_addr;
            at_end_q  <= (next_addr == bus.end_addr);
          end
        end
        DRAIN: if (bus.mem_rvalid) beat_cnt_q <= beat_cnt_q + 1'b1;
        FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_q     <= IDLE;
            dec_flush_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      // seek restart overrides whatever the state branch decided this cycle
      if (enter_flush) begin
        state_q     <= FLUSH;
        mem_req_q   <= 1'b0;
        dec_flush_q <= 1'b1;
        flush_cnt_q <= FW'(FLUSH_CYC - 1);
        rd_addr_q   <= flush_addr;
        at_end_q    <= (flush_addr == bus.end_addr);
        dat_count_q <= '0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (fifo_wr) fifo_q[wr_ptr_q] <= bus.mem_rdata;
  end

  assert property (@(posedge sys_clk_i) disable iff (!rst_n_i) !(fifo_wr && count_q == CW'(DEPTH)));

  assign bus.cmd_ready        = (state_q == IDLE) || (state_q == REQ) || (state_q == DATA);
  assign bus.mem_req          = mem_req_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.stream_valid     = stream_valid;
  assign bus.stream_data      = stream_valid ? fifo_q[rd_ptr_q] : '0;
  assign bus.dec_flush        = dec_flush_q;
  assign bus.playing          = playing_q;
  assign bus.at_end           = at_end_q;
  assign bus.stream_dat_count = dat_count_q;
endmodule

// File: tb/tb_vldp_stream_ctrl.sv
// Bench for vldp_stream_ctrl: a memory responder pushes every kept beat into an expected
// queue, a monitor pops it against each word the decoder side accepts.
module tb_vldp_stream_ctrl;
  localparam int AW = 24;
  localparam int DW = 64;
  localparam int BURST = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vldp_stream_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  vldp_stream_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BURST(BURST), .FLUSH_CYC(4)) dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr = '0;
  int exp_cnt = 0, req_cnt = 0, pop_cnt = 0, pops_at_req = 0;
  int gnt_delay = -1, stall_at = -1, ph = 0;
  bit stall_rel = 0, stalled = 0, discard = 0, gap_mode = 0;

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {8'h5A, a, 8'hC3, ~a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // memory side: one decision per cycle at posedge+1
  initial begin : mem_model
    int dly, beat;
    logic [AW-1:0] ra;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    dly = 0; beat = 0; ra = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_gnt = 0; bus.mem_rvalid = 0;
      if (!rst_n) begin ph = 0; continue; end
      case (ph)
        0: if (bus.mem_req) begin
          ra = bus.mem_addr;
          chk("mem_addr", ra, exp_addr);
          chk("req_before_end", exp_addr < bus.end_addr, 1);
          req_cnt++;
          pops_at_req = pop_cnt;
          dly = (gnt_delay >= 0) ? gnt_delay : $urandom_range(0, 3);
          if (dly == 0) begin bus.mem_gnt = 1; discard = 0; beat = 0; ph = 2; end
          else ph = 1;
        end
        1: begin
          chk("req_hold", {bus.mem_req, bus.mem_addr}, {1'b1, ra});
          dly--;
          if (dly == 0) begin bus.mem_gnt = 1; discard = 0; beat = 0; ph = 2; end
        end
        2: begin
          if (beat == stall_at && !stall_rel) stalled = 1;
          else if (!(gap_mode && $urandom_range(0, 3) == 0)) begin
            bus.mem_rvalid = 1;
            bus.mem_rdata = word(ra + AW'(beat));
            if (!discard) begin exp_q.push_back(word(ra + AW'(beat))); exp_cnt++; end
            beat++;
            if (beat == BURST) begin
              if (!discard) exp_addr = ra + AW'(BURST);
              ph = 3;
            end
          end
        end
        default: begin
          chk("req_spacing", bus.mem_req, 0);
          ph = 0;
        end
      endcase
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.dec_flush) chk("valid_in_flush", bus.stream_valid, 0);
        if (bus.stream_valid && !bus.stream_busy) begin
          pop_cnt++;
          if (exp_q.size() == 0) chk("stream_unexpected", bus.stream_data, 0);
          else chk("stream_data", bus.stream_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a);
    bus.cmd_valid = 1; bus.cmd_op = op; bus.cmd_addr = a;
    chk("cmd_ready", bus.cmd_ready, 1);
    step(1);
    bus.cmd_valid = 0; bus.cmd_op = 2'b00;
  endtask

  task automatic seek_cmd(input logic [AW-1:0] a);
    exp_q.delete();
    exp_cnt = 0;
    exp_addr = a & ~AW'(BURST - 1);
    send_cmd(2'b11, a);
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while (!(exp_addr == bus.end_addr && ph == 0 && exp_q.size() == 0) && n < max) begin
      step(1); n++;
    end
    chk({name, "_timeout"}, n < max, 1);
    step(4);
    chk({name, "_count"}, bus.stream_dat_count, exp_cnt);
    chk({name, "_at_end"}, bus.at_end, 1);
    chk({name, "_no_req"}, bus.mem_req, 0);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_req"}, {bus.mem_req, bus.mem_addr}, 0);
    chk({name, "_stream"}, {bus.stream_valid, bus.stream_data}, 0);
    chk({name, "_flags"}, {bus.dec_flush, bus.playing, bus.at_end, bus.cmd_ready}, 4'b0001);
    chk({name, "_count"}, bus.stream_dat_count, 0);
  endtask

  initial begin : main
    int base, pbase, n, hi;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_addr = '0;
    bus.end_addr = AW'(32); bus.stream_busy = 0;
    step(3);
    check_reset("por");
    rst_n = 1;
    step(2);

    // full run to end_addr=32, immediate grant, back-to-back beats
    gnt_delay = 0; gap_mode = 0; base = req_cnt;
    send_cmd(2'b01, '0);
    chk("play_req_t1", bus.mem_req, 1);
    wait_done("run32", 400);
    step(16);
    chk("run32_bursts", req_cnt - base, 4);
    chk("run32_words", bus.stream_dat_count, 32);

    // seek in IDLE with decoder backpressure: flush timing and FIFO-space throttling
    gnt_delay = -1; gap_mode = 1; bus.stream_busy = 1; bus.end_addr = AW'(64);
    base = req_cnt;
    seek_cmd('0);
    chk("flush_t1", bus.dec_flush, 1);
    for (int i = 2; i <= 4; i++) begin step(1); chk("flush_hold", bus.dec_flush, 1); end
    step(1);
    chk("flush_t5", {bus.dec_flush, bus.mem_req}, 2'b00);
    step(1);
    chk("seek_req_t6", {bus.mem_req, bus.playing}, 2'b11);
    step(100);
    chk("busy_bursts", req_cnt - base, 2);
    chk("busy_idle", {bus.mem_req, bus.stream_valid}, 2'b01);
    chk("busy_count", bus.stream_dat_count, 0);
    base = req_cnt; pbase = pop_cnt;
    bus.stream_busy = 0;
    n = 0;
    while (req_cnt == base && n < 60) begin step(1); n++; end
    chk("third_req_seen", n < 60, 1);
    chk("third_req_after_8", (pops_at_req - pbase >= 8) && (pops_at_req - pbase <= 9), 1);
    wait_done("run64", 600);

    // seek during DATA after three beats: rest of burst discarded
    bus.stream_busy = 1; stall_at = 3; stall_rel = 0; stalled = 0;
    seek_cmd(AW'(8));
    n = 0;
    while (!stalled && n < 80) begin step(1); n++; end
    chk("stall_seen", stalled, 1);
    discard = 1;
    seek_cmd(AW'('h13));
    stall_rel = 1; stall_at = -1;
    n = 0;
    while (!bus.dec_flush && n < 60) begin step(1); n++; end
    hi = 0;
    while (bus.dec_flush && hi < 20) begin step(1); hi++; end
    chk("drain_flush_len", hi, 4);
    chk("drain_count_clr", bus.stream_dat_count, 0);
    bus.stream_busy = 0;
    wait_done("seek13", 600);
    chk("seek13_words", bus.stream_dat_count, 48);

    // PAUSE while the request waits 5 cycles for grant
    gnt_delay = 5; stall_rel = 0;
    seek_cmd('0);
    base = req_cnt;
    n = 0;
    while (!bus.mem_req && n < 20) begin step(1); n++; end
    send_cmd(2'b10, '0);
    step(40);
    chk("pause_one_burst", req_cnt - base, 1);
    chk("pause_state", {bus.playing, bus.mem_req}, 2'b00);
    chk("pause_count", bus.stream_dat_count, 8);
    gnt_delay = -1;
    send_cmd(2'b01, '0);
    chk("resume_req", {bus.mem_req, bus.mem_addr}, {1'b1, AW'(8)});
    wait_done("resume", 600);

    // seek to end_addr, PLAY ignored, seek back to 0 and restart
    send_cmd(2'b10, '0);
    base = req_cnt;
    seek_cmd(AW'(64));
    step(8);
    chk("seek_end_at_end", bus.at_end, 1);
    send_cmd(2'b01, '0);
    step(8);
    chk("play_ignored", {bus.playing, bus.mem_req}, 2'b00);
    seek_cmd('0);
    step(8);
    chk("seek0_state", {bus.at_end, bus.playing}, 2'b00);
    chk("no_req_paused", req_cnt - base, 0);
    stall_at = 2; stalled = 0;
    send_cmd(2'b01, '0);
    chk("restart_req", {bus.mem_req, bus.mem_addr}, {1'b1, AW'(0)});

    // reset mid-burst
    n = 0;
    while (!stalled && n < 40) begin step(1); n++; end
    chk("stall2_seen", stalled, 1);
    #2 rst_n = 0;
    #1 check_reset("async");
    exp_q.delete();
    step(2);
    rst_n = 1;
    stall_at = -1; stalled = 0;
    base = req_cnt;
    step(20);
    chk("post_reset_no_req", {bus.mem_req, 32'(req_cnt - base)}, 0);
    bus.end_addr = AW'(16); exp_addr = '0; exp_cnt = 0;
    send_cmd(2'b01, '0);
    chk("post_reset_play", {bus.mem_req, bus.mem_addr}, {1'b1, AW'(0)});
    wait_done("run16", 300);
    chk("run16_words", bus.stream_dat_count, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
